// File: rtl/line_buffer_ctrl.sv
// Sequencer for the 3x3 window line buffer: tracks frame/line position from vid_io
// timing, drives the ping-pong row RAMs and flags valid windows and line faults.
module line_buffer_ctrl #(
  parameter int MAX_WIDTH = 2048,
  parameter int ADDR_W    = 11,
  parameter int ROW_W     = 12,
  parameter int RD_LEAD   = 2,
  parameter bit VS_POL    = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_en,
  input  logic              i_vid_vsync,
  input  logic              i_vid_VDE,
  output logic [1:0]        o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_sel,
  output logic [ADDR_W-1:0] o_col,
  output logic [ROW_W-1:0]  o_row,
  output logic              o_win_valid,
  output logic              o_frame_start,
  output logic              o_line_done,
  output logic [ADDR_W:0]   o_line_len,
  output logic              o_err_len,
  output logic              o_err_ovf
);

  localparam int CW = ADDR_W + 1;
  localparam int SW = ADDR_W + 2;
  localparam logic [CW-1:0]     COL_MAX  = CW'(MAX_WIDTH);
  localparam logic [CW-1:0]     COL_LAST = CW'(MAX_WIDTH - 1);
  localparam logic [SW-1:0]     RD_LAST  = SW'(MAX_WIDTH - 1);
  localparam logic [SW-1:0]     LEAD     = SW'(RD_LEAD);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(MAX_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_SAT  = '1;

  typedef enum logic [1:0] {WAIT_FRAME, LINE_BLANK, LINE_ACTIVE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_vs_d;
  logic [CW-1:0]     r_col, w_col_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt;
  logic              r_bank, w_bank_nxt;

  logic [CW-1:0]     w_len_nxt;
  logic              w_err_len_nxt, w_err_ovf_nxt;
  logic [1:0]        w_wr_en_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt, w_rd_addr_nxt, w_col_o_nxt;
  logic              w_rd_sel_nxt, w_win_nxt, w_fs_nxt, w_ld_nxt;

  logic              w_vs_edge;
  logic [CW-1:0]     w_pix_col;
  logic [ADDR_W-1:0] w_col_clamp, w_rd_clamp;
  logic [SW-1:0]     w_rd_sum;

  assign w_vs_edge = (i_vid_vsync == VS_POL) && (r_vs_d != VS_POL);

  // A pixel seen outside LINE_ACTIVE is the first of a line, so its column is 0.
  assign w_pix_col   = (r_state == LINE_ACTIVE) ? r_col : '0;
  assign w_col_clamp = (w_pix_col > COL_LAST) ? A_LAST : w_pix_col[ADDR_W-1:0];
  assign w_rd_sum    = {1'b0, w_pix_col} + LEAD;
  assign w_rd_clamp  = (w_rd_sum > RD_LAST) ? A_LAST : w_rd_sum[ADDR_W-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_bank_nxt    = r_bank;
    w_len_nxt     = o_line_len;
    w_err_len_nxt = o_err_len;
    w_err_ovf_nxt = o_err_ovf;
    w_wr_en_nxt   = 2'b00;
    w_wr_addr_nxt = '0;
    w_rd_addr_nxt = '0;
    w_col_o_nxt   = '0;
    w_rd_sel_nxt  = 1'b0;
    w_win_nxt     = 1'b0;
    w_fs_nxt      = 1'b0;
    w_ld_nxt      = 1'b0;

    if (w_vs_edge) begin
      // Frame boundary beats a coincident VDE fall: no line_done for that line.
      w_col_nxt  = '0;
      w_row_nxt  = '0;
      w_bank_nxt = 1'b0;
      if (i_en) begin
        w_state_nxt   = LINE_BLANK;
        w_err_len_nxt = 1'b0;
        w_err_ovf_nxt = 1'b0;
        w_fs_nxt      = 1'b1;
      end else begin
        w_state_nxt = WAIT_FRAME;
      end
    end else if (r_state != WAIT_FRAME) begin
      if (i_vid_VDE) begin
        w_state_nxt   = LINE_ACTIVE;
        w_col_o_nxt   = w_col_clamp;
        w_wr_addr_nxt = w_col_clamp;
        w_rd_addr_nxt = w_rd_clamp;
        w_rd_sel_nxt  = ~r_bank;
        w_win_nxt     = (r_row >= ROW_W'(2)) && (w_pix_col >= CW'(2));
        if (w_pix_col == COL_MAX) begin
          w_err_ovf_nxt = 1'b1;
          w_col_nxt     = COL_MAX;
        end else begin
          w_wr_en_nxt = r_bank ? 2'b10 : 2'b01;
          w_col_nxt   = w_pix_col + CW'(1);
        end
      end else if (r_state == LINE_ACTIVE) begin
        w_state_nxt = LINE_BLANK;
        w_ld_nxt    = 1'b1;
        w_len_nxt   = r_col;
        w_bank_nxt  = ~r_bank;
        w_row_nxt   = (r_row == ROW_SAT) ? r_row : r_row + ROW_W'(1);
        if ((r_row != '0) && (r_col != o_line_len))
          w_err_len_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= WAIT_FRAME;
      r_vs_d        <= VS_POL;  // vsync already high at reset is not an edge
      r_col         <= '0;
      r_row         <= '0;
      r_bank        <= 1'b0;
      o_wr_en       <= 2'b00;
      o_wr_addr     <= '0;
      o_rd_addr     <= '0;
      o_rd_sel      <= 1'b0;
      o_col         <= '0;
      o_row         <= '0;
      o_win_valid   <= 1'b0;
      o_frame_start <= 1'b0;
      o_line_done   <= 1'b0;
      o_line_len    <= '0;
      o_err_len     <= 1'b0;
      o_err_ovf     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_vs_d        <= i_vid_vsync;
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_bank        <= w_bank_nxt;
      o_wr_en       <= w_wr_en_nxt;
      o_wr_addr     <= w_wr_addr_nxt;
      o_rd_addr     <= w_rd_addr_nxt;
      o_rd_sel      <= w_rd_sel_nxt;
      o_col         <= w_col_o_nxt;
      o_row         <= w_row_nxt;
      o_win_valid   <= w_win_nxt;
      o_frame_start <= w_fs_nxt;
      o_line_done   <= w_ld_nxt;
      o_line_len    <= w_len_nxt;
      o_err_len     <= w_err_len_nxt;
      o_err_ovf     <= w_err_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: directed and random vid_io timing against a
// line-level reference model, with a narrow MAX_WIDTH so overflow is reachable.
module tb_line_buffer_ctrl;
  localparam int MAXW = 16;
  localparam int AW   = 4;
  localparam int RW   = 3;
  localparam int RMAX = 7;

  logic clk = 1'b0;
  logic n_rst = 1'b0, i_en = 1'b0, vs = 1'b0, vde = 1'b0;
  logic [1:0]    o_wr_en;
  logic [AW-1:0] o_wr_addr, o_rd_addr, o_col;
  logic          o_rd_sel, o_win_valid, o_frame_start, o_line_done, o_err_len, o_err_ovf;
  logic [RW-1:0] o_row;
  logic [AW:0]   o_line_len;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.MAX_WIDTH(MAXW), .ADDR_W(AW), .ROW_W(RW), .RD_LEAD(2), .VS_POL(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .i_en(i_en), .i_vid_vsync(vs), .i_vid_VDE(vde),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_rd_addr(o_rd_addr), .o_rd_sel(o_rd_sel),
    .o_col(o_col), .o_row(o_row), .o_win_valid(o_win_valid), .o_frame_start(o_frame_start),
    .o_line_done(o_line_done), .o_line_len(o_line_len), .o_err_len(o_err_len), .o_err_ovf(o_err_ovf)
  );

  int n_cmp = 0, n_err = 0;
  int fs_cnt, wr_cnt, win_r2, first_win;

  // reference state: mode 0 = no frame, 1 = between lines, 2 = inside a line
  int m_mode, m_col, m_row, m_bank, m_len, m_elen, m_eovf;
  bit m_vs_prev;
  int e_wr_en, e_wr_addr, e_rd_addr, e_rd_sel, e_col, e_win, e_fs, e_ld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_cycle();
    int c;
    e_wr_en = 0; e_wr_addr = 0; e_rd_addr = 0; e_rd_sel = 0;
    e_col = 0; e_win = 0; e_fs = 0; e_ld = 0;
    if (!n_rst) begin
      m_mode = 0; m_col = 0; m_row = 0; m_bank = 0; m_len = 0; m_elen = 0; m_eovf = 0;
      m_vs_prev = 1'b1;
      return;
    end
    if (vs && !m_vs_prev) begin
      m_col = 0; m_row = 0; m_bank = 0;
      if (i_en) begin m_mode = 1; m_elen = 0; m_eovf = 0; e_fs = 1; end
      else m_mode = 0;
    end else if (m_mode != 0) begin
      if (vde) begin
        c = (m_mode == 2) ? m_col : 0;
        e_col     = (c < MAXW) ? c : MAXW - 1;
        e_wr_addr = e_col;
        e_wr_en   = (c < MAXW) ? (m_bank ? 2 : 1) : 0;
        e_rd_addr = (c + 2 > MAXW - 1) ? MAXW - 1 : c + 2;
        e_rd_sel  = m_bank ? 0 : 1;
        e_win     = (m_row >= 2 && c >= 2) ? 1 : 0;
        if (c >= MAXW) m_eovf = 1;
        m_col  = (c + 1 > MAXW) ? MAXW : c + 1;
        m_mode = 2;
      end else if (m_mode == 2) begin
        e_ld = 1;
        if (m_row >= 1 && m_col != m_len) m_elen = 1;
        m_len  = m_col;
        m_bank = 1 - m_bank;
        m_row  = (m_row < RMAX) ? m_row + 1 : RMAX;
        m_mode = 1;
      end
    end
    m_vs_prev = vs;
  endtask

  task automatic step(input logic vs_i, input logic vde_i);
    vs = vs_i; vde = vde_i;
    model_cycle();
    @(posedge clk);
    #1;
    chk("wr_en", o_wr_en, e_wr_en);
    chk("wr_addr", o_wr_addr, e_wr_addr);
    chk("rd_addr", o_rd_addr, e_rd_addr);
    chk("rd_sel", o_rd_sel, e_rd_sel);
    chk("col", o_col, e_col);
    chk("row", o_row, m_row);
    chk("win_valid", o_win_valid, e_win);
    chk("frame_start", o_frame_start, e_fs);
    chk("line_done", o_line_done, e_ld);
    chk("line_len", o_line_len, m_len);
    chk("err_len", o_err_len, m_elen);
    chk("err_ovf", o_err_ovf, m_eovf);
    if (o_frame_start) fs_cnt++;
    if (o_wr_en != 2'b00) wr_cnt++;
    if (o_win_valid && o_row == 2) win_r2++;
    if (o_win_valid && first_win < 0) first_win = o_row * 100 + o_col;
  endtask

  task automatic line(input int n, input int blank);
    repeat (n) step(1'b0, 1'b1);
    repeat (blank) step(1'b0, 1'b0);
  endtask

  task automatic vsync();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    fs_cnt = 0; wr_cnt = 0; win_r2 = 0; first_win = -1;
    i_en = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    n_rst = 1'b1;

    // VDE without any vsync is ignored
    line(6, 2); line(4, 2);
    chk("novs_fs_cnt", fs_cnt, 0);
    chk("novs_wr_cnt", wr_cnt, 0);

    // three 8-pixel lines: banks 01,10,01 and six valid windows on row 2
    vsync();
    win_r2 = 0; first_win = -1;
    line(8, 3); line(8, 3); line(8, 3);
    chk("win_row2_cnt", win_r2, 6);
    chk("first_win_rc", first_win, 202);
    chk("len_8", o_line_len, 8);

    // 8 then 7 pixels: length error, cleared by next frame start
    vsync();
    line(8, 2); line(7, 2);
    chk("err_len_set", o_err_len, 1);
    step(1'b1, 1'b0);
    chk("err_len_clr", o_err_len, 0);
    step(1'b0, 1'b0);

    // 20-pixel line against a 16-deep RAM
    wr_cnt = 0;
    line(20, 2);
    chk("ovf_wr_cnt", wr_cnt, 16);
    chk("ovf_flag", o_err_ovf, 1);
    chk("ovf_len", o_line_len, 16);
    line(16, 1);

    // vsync on the cycle VDE falls
    vsync();
    line(5, 1); line(5, 0);
    step(1'b1, 1'b0);
    chk("coinc_fs", o_frame_start, 1);
    chk("coinc_ld", o_line_done, 0);
    chk("coinc_row", o_row, 0);
    step(1'b0, 1'b0);

    // row counter saturates
    repeat (10) line(3, 1);
    chk("row_sat", o_row, RMAX);

    // enable dropped mid-frame: frame completes, next vsync parks the block
    i_en = 1'b0;
    wr_cnt = 0;
    line(4, 1);
    chk("en0_frame_runs", wr_cnt, 4);
    vsync();
    wr_cnt = 0;
    line(4, 1);
    chk("en0_parked", wr_cnt, 0);
    i_en = 1'b1;

    // random timing
    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        i_en = ($urandom_range(0, 3) != 0);
        vsync();
      end else if (r == 1) begin
        line(int'($urandom_range(1, 18)), 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end else begin
        line(int'($urandom_range(1, 19)), int'($urandom_range(1, 3)));
      end
    end
    i_en = 1'b1;

    // reset in the middle of a line
    vsync();
    line(8, 2);
    repeat (5) step(1'b0, 1'b1);
    n_rst = 1'b0;
    step(1'b0, 1'b1);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_line_len", o_line_len, 0);
    n_rst = 1'b1;
    wr_cnt = 0;
    repeat (4) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_needs_vsync", wr_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
